// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/table-update bundle for the branch resolve queue.
// The block under test takes the slave side; fetch/execute/table models take the master side.
interface branch_resolve_queue_if #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Handshake: a prediction is accepted on a rising edge where pred_valid and pred_ready
    // are both high. pred_ready depends only on registered occupancy. A held pred_valid with
    // pred_ready low is ignored, and the sender keeps it asserted. res_valid has no ready signal:
    // it resolves the oldest entry in that cycle, or sets res_err if the queue is empty.
    logic             pred_valid;
    logic [LOWER-1:0] pred_idx;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_jump;
    logic             upd_en;
    logic [LOWER-1:0] upd_idx;
    logic             upd_taken;
    logic             flush;
    logic             flush_taken;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic             res_err;

    modport master (
        output pred_valid, pred_idx, pred_taken, res_valid, res_taken, res_jump,
        input  pred_ready, upd_en, upd_idx, upd_taken, flush, flush_taken,
               occupancy, branch_cnt, mispred_cnt, res_err
    );

    modport slave (
        input  pred_valid, pred_idx, pred_taken, res_valid, res_taken, res_jump,
        output pred_ready, upd_en, upd_idx, upd_taken, flush, flush_taken,
               occupancy, branch_cnt, mispred_cnt, res_err
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. It checks the oldest entry against the
// resolved outcome, then drives the history table update and a one-cycle flush on a mispredict.
module branch_resolve_queue #(
    parameter int LOWER = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    branch_resolve_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [LOWER-1:0] r_idx [DEPTH];
    logic             r_tkn [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_bcnt;
    logic [CNT_W-1:0] r_mcnt;
    logic             r_err;
    logic             r_upd_en;
    logic [LOWER-1:0] r_upd_idx;
    logic             r_upd_tkn;
    logic             r_flush;
    logic             r_flush_tkn;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_actual;
    logic w_mis;
    logic w_push;

    assign w_full   = (r_occ == OCC_W'(DEPTH));
    assign w_empty  = (r_occ == '0);
    assign w_pop    = bus.res_valid & ~w_empty;
    assign w_actual = bus.res_taken | bus.res_jump;
    assign w_mis    = w_pop & (r_tkn[r_head] != w_actual);
    // A push on the same edge as a mispredict pop comes from the wrong path, so it is dropped.
    assign w_push   = bus.pred_valid & ~w_full & ~w_mis;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx[r_tail] <= bus.pred_idx;
            r_tkn[r_tail] <= bus.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (w_mis) begin
            r_head <= r_head + PTR_W'(1);
            r_tail <= r_head + PTR_W'(1);
            r_occ  <= '0;
        end else begin
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt      <= '0;
            r_mcnt      <= '0;
            r_err       <= 1'b0;
            r_upd_en    <= 1'b0;
            r_upd_idx   <= '0;
            r_upd_tkn   <= 1'b0;
            r_flush     <= 1'b0;
            r_flush_tkn <= 1'b0;
        end else begin
            r_upd_en <= w_pop;
            r_flush  <= w_mis;
            if (w_pop) begin
                r_upd_idx   <= r_idx[r_head];
                r_upd_tkn   <= w_actual;
                r_flush_tkn <= w_actual;
                if (r_bcnt != '1) r_bcnt <= r_bcnt + CNT_W'(1);
            end
            if (w_mis && r_mcnt != '1) r_mcnt <= r_mcnt + CNT_W'(1);
            if (bus.res_valid && w_empty) r_err <= 1'b1;
        end
    end

    assign bus.pred_ready  = ~w_full;
    assign bus.upd_en      = r_upd_en;
    assign bus.upd_idx     = r_upd_idx;
    assign bus.upd_taken   = r_upd_tkn;
    assign bus.flush       = r_flush;
    assign bus.flush_taken = r_flush_tkn;
    assign bus.occupancy   = r_occ;
    assign bus.branch_cnt  = r_bcnt;
    assign bus.mispred_cnt = r_mcnt;
    assign bus.res_err     = r_err;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: a wide-counter and a 2-bit-counter instance share stimulus
// and are checked each cycle against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int LOWER = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_a ();
    branch_resolve_queue_if #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(2))     bus_b ();

    branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    branch_resolve_queue #(.LOWER(LOWER), .DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    // Model state: each queue entry is {idx, taken}.
    logic [LOWER:0]   m_q [$];
    int               m_bcnt, m_mcnt, m_bcnt2, m_mcnt2;
    logic             m_err;
    logic             e_upd_en, e_upd_taken, e_flush, e_flush_taken;
    logic [LOWER-1:0] e_upd_idx;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input logic [LOWER-1:0] pidx, input logic pt,
                         input logic rv, input logic rt, input logic rj);
        bus_a.pred_valid = pv; bus_a.pred_idx = pidx; bus_a.pred_taken = pt;
        bus_a.res_valid  = rv; bus_a.res_taken = rt;  bus_a.res_jump  = rj;
        bus_b.pred_valid = pv; bus_b.pred_idx = pidx; bus_b.pred_taken = pt;
        bus_b.res_valid  = rv; bus_b.res_taken = rt;  bus_b.res_jump  = rj;
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic check_all();
        check_eq("occupancy",   32'(bus_a.occupancy),   32'(m_q.size()));
        check_eq("pred_ready",  32'(bus_a.pred_ready),  32'(m_q.size() != DEPTH));
        check_eq("upd_en",      32'(bus_a.upd_en),      32'(e_upd_en));
        check_eq("upd_idx",     32'(bus_a.upd_idx),     32'(e_upd_idx));
        check_eq("upd_taken",   32'(bus_a.upd_taken),   32'(e_upd_taken));
        check_eq("flush",       32'(bus_a.flush),       32'(e_flush));
        check_eq("flush_taken", 32'(bus_a.flush_taken), 32'(e_flush_taken));
        check_eq("branch_cnt",  32'(bus_a.branch_cnt),  32'(m_bcnt));
        check_eq("mispred_cnt", 32'(bus_a.mispred_cnt), 32'(m_mcnt));
        check_eq("res_err",     32'(bus_a.res_err),     32'(m_err));
        check_eq("b_occupancy", 32'(bus_b.occupancy),   32'(m_q.size()));
        check_eq("b_branch",    32'(bus_b.branch_cnt),  32'(m_bcnt2));
        check_eq("b_mispred",   32'(bus_b.mispred_cnt), 32'(m_mcnt2));
    endtask

    // One clock: apply inputs, advance the model, then check after the edge.
    task automatic step(input logic pv, input logic [LOWER-1:0] pidx, input logic pt,
                        input logic rv, input logic rt, input logic rj);
        logic full, pop, actual, mis;
        drive(pv, pidx, pt, rv, rt, rj);
        full   = (m_q.size() == DEPTH);
        pop    = rv && (m_q.size() != 0);
        actual = rt | rj;
        mis    = pop && (m_q[0][0] != actual);
        e_upd_en = pop;
        e_flush  = mis;
        if (pop) begin
            e_upd_idx     = m_q[0][LOWER:1];
            e_upd_taken   = actual;
            e_flush_taken = actual;
            m_bcnt  = sat_inc(m_bcnt, 65535);
            m_bcnt2 = sat_inc(m_bcnt2, 3);
            void'(m_q.pop_front());
        end
        if (mis) begin
            m_mcnt  = sat_inc(m_mcnt, 65535);
            m_mcnt2 = sat_inc(m_mcnt2, 3);
            m_q.delete();
        end
        if (rv && !pop) m_err = 1'b1;
        if (pv && !full && !mis) m_q.push_back({pidx, pt});
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Reset with random inputs applied, which also shows that reset takes priority.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, LOWER'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_bcnt = 0; m_mcnt = 0; m_bcnt2 = 0; m_mcnt2 = 0; m_err = 1'b0;
        e_upd_en = 0; e_upd_idx = '0; e_upd_taken = 0; e_flush = 0; e_flush_taken = 0;
        check_all();
        check_eq("rst_ready", 32'(bus_a.pred_ready), 32'd1);
    endtask

    initial begin
        drive(0, '0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Basic push/resolve.
        step(1, 5'd3, 1, 0, 0, 0);
        step(1, 5'd7, 0, 0, 0, 0);
        check_eq("two_pushed", 32'(bus_a.occupancy), 32'd2);
        step(0, '0, 0, 1, 1, 0);
        check_eq("first_upd_idx", 32'(bus_a.upd_idx), 32'd3);
        check_eq("first_flush", 32'(bus_a.flush), 32'd0);

        // A mispredicted jump flushes the younger entries and the same-cycle push.
        do_reset();
        step(1, 5'd9, 0, 0, 0, 0);
        step(1, 5'd10, 1, 0, 0, 0);
        step(1, 5'd11, 0, 0, 0, 0);
        step(1, 5'd12, 1, 1, 0, 1);
        check_eq("mis_flush", 32'(bus_a.flush), 32'd1);
        check_eq("mis_occ", 32'(bus_a.occupancy), 32'd0);

        // Fill the queue, send a push while full, then resolve and push in the same cycle.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1, LOWER'(i + 1), 0, 0, 0, 0);
        check_eq("full_ready", 32'(bus_a.pred_ready), 32'd0);
        step(1, 5'd20, 0, 1, 0, 0);
        check_eq("after_full_occ", 32'(bus_a.occupancy), 32'd3);

        // Six correctly predicted branches, one at a time, so the pointers wrap.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, LOWER'(i * 5 + 2), 1, 0, 0, 0);
            step(0, '0, 0, 1, 1, 0);
        end
        check_eq("six_branches", 32'(bus_a.branch_cnt), 32'd6);

        // Resolve while empty, with a push in the same cycle.
        step(0, '0, 0, 1, 0, 0);
        step(1, 5'd4, 1, 1, 1, 0);
        step(0, '0, 0, 0, 0, 0);
        check_eq("err_sticky", 32'(bus_a.res_err), 32'd1);

        // Five mispredicts saturate the 2-bit counters.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, LOWER'(i), 1, 0, 0, 0);
            step(0, '0, 0, 1, 0, 0);
        end
        check_eq("sat_mispred", 32'(bus_b.mispred_cnt), 32'd3);

        // Reset while two entries are held.
        step(1, 5'd1, 0, 0, 0, 0);
        step(1, 5'd2, 1, 0, 0, 0);
        do_reset();

        // Randomized traffic with an occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 99) < 60, LOWER'($urandom), 1'($urandom),
                      $urandom_range(0, 99) < 45, 1'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
